// File: rtl/alu_pkg.sv
// Opcodes, flag bit positions and FSM states shared by alu_mc and its helpers.
// Build option ALU_MC_MULDIV_EN adds the BUSY state used by the iterative mul/div path.
package alu_pkg;

  localparam logic [3:0] ALU_OR   = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_NAND = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SUB  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_REMU = 4'd14;
  localparam logic [3:0] ALU_RSVD = 4'd15;

  localparam int unsigned FLG_ZERO  = 0;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_OVF   = 2;
  localparam int unsigned FLG_NEG   = 3;

`ifdef ALU_MC_MULDIV_EN
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
`else
  typedef enum logic {ST_IDLE, ST_DONE} state_t;
`endif

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unit: shift-add multiplier (low WIDTH bits) and restoring divider,
// one step per cycle for WIDTH cycles after start_i.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  // acc: partial product / partial remainder; b: multiplicand / divisor;
  // c: multiplier shifting out / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    c_d     = c_q;
    shifted = {acc_q, c_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_d = trial[WIDTH-1:0];
        c_d   = {c_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        c_d   = {c_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (c_q[0]) acc_d = acc_q + b_q;
      b_d = b_q << 1;
      c_d = c_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      c_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      cnt_q  <= CW'(WIDTH - 1);
      acc_q  <= '0;
      b_q    <= opb_i;
      c_q    <= opa_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  // Outputs expose the final step combinationally so the caller can latch them on done_o.
  assign done_o      = busy_q && (cnt_q == '0);
  assign product_o   = acc_d;
  assign quotient_o  = c_d;
  assign remainder_o = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and {neg,ovf,carry,zero} flags.
// Define ALU_MC_MULDIV_EN to enable iterative MUL/DIVU/REMU; otherwise they are illegal.
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [OPW-1:0]   aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;
  logic             accept;

  logic [WIDTH-1:0] sc_res;
  logic [3:0]       sc_flags;
  logic             sc_ill;
  logic             sc_carry, sc_ovf;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;

  assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

  // Mul/div opcodes fall into the default arm here; their result comes from the sequencer.
  always_comb begin
    sum      = {1'b0, op1} + {1'b0, op2};
    diff     = {1'b0, op1} - {1'b0, op2};
    shamt    = op2[SHW-1:0];
    sc_res   = '0;
    sc_ill   = 1'b0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (aluop)
      ALU_OR:   sc_res = op1 | op2;
      ALU_AND:  sc_res = op1 & op2;
      ALU_XOR:  sc_res = op1 ^ op2;
      ALU_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_NOR:  sc_res = ~(op1 | op2);
      ALU_NAND: sc_res = ~(op1 & op2);
      ALU_SLTU: sc_res = WIDTH'(diff[WIDTH]);
      ALU_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_SLT:  sc_res = WIDTH'($signed(op1) < $signed(op2));
      ALU_SLL:  sc_res = op1 << shamt;
      ALU_SRL:  sc_res = op1 >> shamt;
      ALU_SRA:  sc_res = $unsigned($signed(op1) >>> shamt);
      default:  sc_ill = 1'b1;
    endcase
    sc_flags            = '0;
    sc_flags[FLG_ZERO]  = (sc_res == '0);
    sc_flags[FLG_CARRY] = sc_carry;
    sc_flags[FLG_OVF]   = sc_ovf;
    sc_flags[FLG_NEG]   = sc_res[WIDTH-1];
  end

`ifdef ALU_MC_MULDIV_EN
  logic [OPW-1:0]   op_q;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_prod, md_quo, md_rem, md_res;

  assign md_start = accept && is_muldiv(aluop);
  assign md_res   = (op_q == ALU_MUL)  ? md_prod :
                    (op_q == ALU_DIVU) ? md_quo  : md_rem;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start_i     (md_start),
    .div_i       (aluop != ALU_MUL),
    .opa_i       (op1),
    .opb_i       (op2),
    .done_o      (md_done),
    .product_o   (md_prod),
    .quotient_o  (md_quo),
    .remainder_o (md_rem)
  );

  always_ff @(posedge clk) begin
    if (rst)         op_q <= '0;
    else if (accept) op_q <= aluop;
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (accept) begin
`ifdef ALU_MC_MULDIV_EN
      if (md_start) begin
        state_d = ST_BUSY;
      end else
`endif
      begin
        state_d   = ST_DONE;
        result_d  = sc_res;
        flags_d   = sc_flags;
        illegal_d = sc_ill;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
`ifdef ALU_MC_MULDIV_EN
    else if ((state_q == ST_BUSY) && md_done) begin
      state_d           = ST_DONE;
      result_d          = md_res;
      flags_d           = '0;
      flags_d[FLG_ZERO] = (md_res == '0);
      flags_d[FLG_NEG]  = md_res[WIDTH-1];
      illegal_d         = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the datapath ALU, with the same eight base operations.
- Adds signed compare, shifts, condition flags, and iterative multiply/divide.
- Uses a valid/ready handshake so the pipeline control can stall on long operations.
- Sits between the register-read stage and the write-back mux.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 4, power of 2).
- OPW, 4, opcode width. Fixed at 4; not overridable in practice.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  operand B.
- aluop  in  OPW  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- flags  out  4  {neg, ovf, carry, zero}.
- illegal  out  1  aluop was not a supported operation.

Behaviour:
- Opcodes, encodings 0–7 identical to the current ALU:
  - 0 OR, 1 AND, 2 XOR, 3 ADD, 4 NOR, 5 NAND.
  - 6 SLTU: unsigned, result 1/0.
  - 7 SUB (op1-op2).
  - 8 SLT: signed.
  - 9 SLL, 10 SRL, 11 SRA.
  - 12 MUL: low WIDTH bits.
  - 13 DIVU, 14 REMU.
  - 15 reserved.
- Shifts: amount is op2[$clog2(WIDTH)-1:0]; upper bits ignored.
- Arithmetic: ADD/SUB are modulo 2^WIDTH.
  - carry = carry-out for ADD, borrow (op1<op2 unsigned) for SUB, else 0.
  - ovf = signed overflow for ADD/SUB, else 0.
  - zero = (result==0); neg = result[WIDTH-1].
- Divide by zero: DIVU gives all-ones; REMU gives op1. No exception.
- FSM states IDLE, BUSY, DONE.
  - Accept occurs when in_valid & in_ready. Operands and opcode are registered on accept.
  - in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 while rst=1.
  - Single-cycle op accepted at cycle t: go to DONE; out_valid=1 at t+1.
  - MUL/DIVU/REMU accepted at t: go to BUSY with counter = WIDTH-1.
    - One shift-add / restoring-subtract step per cycle.
    - Leave BUSY when the counter hits 0; out_valid=1 at t+WIDTH+1.
  - DONE: out_valid=1. result, flags and illegal are held stable until out_ready.
    - On out_ready without a new accept: go to IDLE.
    - On out_ready with a simultaneous accept: start the new op, with no idle bubble.
  - In IDLE/BUSY: out_valid=0. result/flags/illegal keep their last values.
- Reset values: out_valid=0, result=0, flags=0, illegal=0, state=IDLE, counter=0.
- Reset mid-operation: BUSY or DONE contents are discarded with no output handshake. The next accepted op computes correctly.
- Opcode 15: single-cycle; result=0, flags=0 except zero=1, illegal=1.
- Changes on op1/op2/aluop while not accepting have no effect.

Optional Feature:
- Macro: ALU_MC_MULDIV_EN.
- Defined: the iterative multiply/divide unit is instantiated; opcodes 12–14 behave as above.
- Undefined:
  - Opcodes 12–14 are treated like opcode 15: single-cycle, result=0, illegal=1.
  - The BUSY state and counter are removed.
  - Every op has 1-cycle latency.

Decomposition:
- alu_pkg holds:
  - opcode localparams (ALU_OR..ALU_REMU, ALU_RSVD);
  - flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_NEG=3);
  - FSM state encodings.
- One sub-module, alu_muldiv_seq: iterative shift-add multiplier / restoring divider.
  - Ports: clk, rst, start, op select, operands, done, product/quotient/remainder.
  - Instantiated only under ALU_MC_MULDIV_EN.
- Single-cycle logic stays in alu_mc.

Test Plan (WIDTH=32, ALU_MC_MULDIV_EN defined):
- ADD 0x7FFFFFFF+0x00000001, accept at t → out_valid at t+1, result 0x80000000, flags neg=1 ovf=1 carry=0 zero=0.
- SLT 0xFFFFFFFF vs 0x00000001 → 1. SLTU same operands → 0. SUB 5-5 → 0, zero=1, carry=0.
- MUL 7*6, accept at t → out_valid first at t+33, result 42, in_ready=0 during t+1..t+32. MUL 0x00010000*0x00010000 → 0, zero=1.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Backpressure: XOR result held with out_ready=0 for 5 cycles → result/flags stable, in_ready=0. Then out_ready=1 with ADD in_valid the same cycle → ADD accepted, its result valid the next cycle.
- rst=1 at 10 cycles into a MUL → out_valid=0, result=0 next cycle. Subsequent SRA 0x80000000 by 4 → 0xF8000000. aluop=15 → illegal=1, result=0.
